// File: rtl/axicb_mst_wr_sched_pkg.sv
// Shared types for the per-master write-data scheduler: the order-FIFO
// entry layout and the AXI length width.
package axicb_pkg;

   localparam int AXI_LEN_W    = 8;
   localparam int AXICB_SLV_NB = 4;

   // One outstanding AW as remembered by the order FIFO.
   typedef struct packed {
      logic [AXI_LEN_W-1:0]    len;
      logic [AXICB_SLV_NB-1:0] ix;
      logic                    mr;
   } axicb_wr_ent_t;

endpackage

// File: rtl/axicb_mst_wr_sched_if.sv
// AW-record and W-steering signals between a master port and its write
// scheduler. The master modport is the side feeding AW/W and slave WREADY;
// the slave modport is the scheduler itself.
interface axicb_mst_wr_sched_if
   import axicb_pkg::*;
#(
   parameter int SLV_NB = AXICB_SLV_NB
);

   logic                 aw_valid;
   logic                 aw_ready;
   logic [SLV_NB-1:0]    aw_ix;
   logic                 aw_mr;
   logic [AXI_LEN_W-1:0] aw_len;
   logic                 aw_full;
   logic                 w_valid;
   logic                 w_last;
   logic                 w_ready;
   logic [SLV_NB-1:0]    slv_wready;
   logic [SLV_NB-1:0]    w_grant;
   logic                 w_mr;
   logic                 len_err;

   modport master (
      output aw_valid, aw_ready, aw_ix, aw_mr, aw_len,
      output w_valid, w_last, slv_wready,
      input  aw_full, w_ready, w_grant, w_mr, len_err
   );

   modport slave (
      input  aw_valid, aw_ready, aw_ix, aw_mr, aw_len,
      input  w_valid, w_last, slv_wready,
      output aw_full, w_ready, w_grant, w_mr, len_err
   );

endinterface

// File: rtl/axicb_mst_wr_sched_scfifo.sv
// Single-clock register-file FIFO storage with wrapping read/write pointers.
// Occupancy and full/empty tracking belong to the instantiating block.
module axicb_scfifo #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  aclk,
   input  logic                  srst,
   input  logic                  wr_en_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;

   // Pointers advance by one per access; power-of-two depth gives free wrap.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_en_i) rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   // Pointer registers.
   always_ff @(posedge aclk) begin
      if (srst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is data only; stale contents are never read while empty.
   always_ff @(posedge aclk) begin
      if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/axicb_mst_wr_sched.sv
// Per-master write-data scheduler. Accepted AWs are queued in order; W beats
// are steered to the slave of the head entry until WLAST, then the next
// entry takes over. Misrouted entries sink their beats locally.
// Optional build macro AXICB_WR_SCHED_LEN_CHECK_EN stores AWLEN per entry and
// flags WLAST/AWLEN disagreement on len_err.
// SLV_NB must match the entry width declared in axicb_pkg.
module axicb_mst_wr_sched
   import axicb_pkg::*;
#(
   parameter int SLV_NB   = AXICB_SLV_NB,
   parameter int OSTD_NUM = 4
) (
   input  logic                 aclk,
   input  logic                 srst,
   axicb_mst_wr_sched_if.slave  bus
);

   localparam int ADDR_W = $clog2(OSTD_NUM);
   localparam int CNT_W  = ADDR_W + 1;
   localparam logic [CNT_W-1:0] CNT_ONE  = 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OSTD_NUM);

`ifdef AXICB_WR_SCHED_LEN_CHECK_EN
   localparam int ENT_W = $bits(axicb_wr_ent_t);
`else
   localparam int ENT_W = SLV_NB + 1;
`endif

   logic [CNT_W-1:0]  count_q, count_d;
   logic              full_q, full_d;
   logic              push, pop, beat_acc, head_vld;
   logic [ENT_W-1:0]  fifo_wr_data, fifo_rd_data;
   logic [SLV_NB-1:0] head_ix;
   logic              head_mr;
   logic [SLV_NB-1:0] grant;
   logic              mr_out, ready_out;

   // A push while full is an upstream fault and is dropped here.
   assign push     = bus.aw_valid & bus.aw_ready & ~full_q;
   assign beat_acc = bus.w_valid & ready_out;
   assign pop      = beat_acc & bus.w_last;
   assign head_vld = (count_q != '0);

`ifdef AXICB_WR_SCHED_LEN_CHECK_EN
   axicb_wr_ent_t push_ent, head_ent;
   assign push_ent     = '{len: bus.aw_len, ix: bus.aw_ix, mr: bus.aw_mr};
   assign fifo_wr_data = push_ent;
   assign head_ent     = fifo_rd_data;
   assign head_ix      = head_ent.ix;
   assign head_mr      = head_ent.mr;
`else
   assign fifo_wr_data       = {bus.aw_ix, bus.aw_mr};
   assign {head_ix, head_mr} = fifo_rd_data;
`endif

   axicb_scfifo #(
      .ADDR_WIDTH (ADDR_W),
      .DATA_WIDTH (ENT_W)
   ) u_order_fifo (
      .aclk      (aclk),
      .srst      (srst),
      .wr_en_i   (push),
      .wr_data_i (fifo_wr_data),
      .rd_en_i   (pop),
      .rd_data_o (fifo_rd_data)
   );

   // Occupancy: simultaneous push and pop leave it unchanged; full is
   // registered from the next count so it tracks count with no extra lag.
   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      full_d = (count_d == CNT_FULL);
   end

   // Occupancy and full flag registers.
   always_ff @(posedge aclk) begin
      if (srst) begin
         count_q <= '0;
         full_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         full_q  <= full_d;
      end
   end

   // Head decode: steer to the head slave, or sink beats of a misroute.
   always_comb begin
      grant     = '0;
      mr_out    = 1'b0;
      ready_out = 1'b0;
      if (head_vld) begin
         if (head_mr) begin
            mr_out    = 1'b1;
            ready_out = 1'b1;
         end else begin
            grant     = head_ix;
            ready_out = |(bus.slv_wready & head_ix);
         end
      end
   end

   assign bus.w_grant = grant;
   assign bus.w_mr    = mr_out;
   assign bus.w_ready = ready_out;
   assign bus.aw_full = full_q;

`ifdef AXICB_WR_SCHED_LEN_CHECK_EN
   logic [AXI_LEN_W-1:0] beat_cnt_q, beat_cnt_d;
   logic                 len_err_q, len_err_d;

   // Beat counter within the head burst; WLAST must land exactly on beat len.
   always_comb begin
      beat_cnt_d = beat_cnt_q;
      len_err_d  = 1'b0;
      if (beat_acc) begin
         if (bus.w_last) begin
            len_err_d  = (beat_cnt_q != head_ent.len);
            beat_cnt_d = '0;
         end else begin
            len_err_d  = (beat_cnt_q == head_ent.len);
            beat_cnt_d = beat_cnt_q + 1'b1;
         end
      end
   end

   // Counter and one-cycle error pulse registers.
   always_ff @(posedge aclk) begin
      if (srst) begin
         beat_cnt_q <= '0;
         len_err_q  <= 1'b0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         len_err_q  <= len_err_d;
      end
   end

   assign bus.len_err = len_err_q;
`else
   assign bus.len_err = 1'b0;
`endif

   // Upstream must hold aw_ready low while aw_full is asserted.
   a_no_push_when_full: assert property (
      @(posedge aclk) disable iff (srst) !(bus.aw_valid && bus.aw_ready && full_q)
   );

endmodule

// File: tb/tb_axicb_mst_wr_sched.sv
// Bench for axicb_mst_wr_sched: directed scenarios followed by random traffic,
// all checked every cycle against a queue-based model of the AW order.
module tb_axicb_mst_wr_sched;
   import axicb_pkg::*;

   localparam int SLV_NB = 4;
   localparam int OSTD   = 4;
`ifdef AXICB_WR_SCHED_LEN_CHECK_EN
   localparam bit LEN_CHK = 1'b1;
`else
   localparam bit LEN_CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic srst;
   always #5 clk = ~clk;

   axicb_mst_wr_sched_if #(.SLV_NB(SLV_NB)) bus_if ();

   axicb_mst_wr_sched #(
      .SLV_NB   (SLV_NB),
      .OSTD_NUM (OSTD)
   ) dut (
      .aclk (clk),
      .srst (srst),
      .bus  (bus_if)
   );

   typedef struct {
      logic [3:0] ix;
      bit         mr;
      int         len;
   } ent_t;

   ent_t q[$];
   int   mcnt;
   bit   err_pend;
   int   n_chk;
   int   n_pass;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   function automatic bit m_ready();
      if (q.size() == 0) return 1'b0;
      if (q[0].mr) return 1'b1;
      return |(bus_if.slv_wready & q[0].ix);
   endfunction

   // Check outputs against the model mid-cycle, then advance the model
   // with the inputs that the coming rising edge will sample.
   task automatic cycle();
      bit   rdy, acc, do_push;
      ent_t e;
      @(negedge clk);
      rdy = m_ready();
      chk("w_grant", 32'(bus_if.w_grant), (q.size() != 0 && !q[0].mr) ? 32'(q[0].ix) : 32'd0);
      chk("w_mr", 32'(bus_if.w_mr), (q.size() != 0) ? 32'(q[0].mr) : 32'd0);
      chk("w_ready", 32'(bus_if.w_ready), 32'(rdy));
      chk("aw_full", 32'(bus_if.aw_full), 32'(q.size() == OSTD));
      chk("len_err", 32'(bus_if.len_err), 32'(err_pend));
      if (srst) begin
         q.delete();
         mcnt     = 0;
         err_pend = 1'b0;
      end else begin
         acc      = bus_if.w_valid && rdy;
         do_push  = bus_if.aw_valid && bus_if.aw_ready && (q.size() < OSTD);
         err_pend = 1'b0;
         if (acc) begin
            if (LEN_CHK) err_pend = bus_if.w_last ? (mcnt != q[0].len) : (mcnt == q[0].len);
            if (bus_if.w_last) begin
               mcnt = 0;
               void'(q.pop_front());
            end else begin
               mcnt = (mcnt + 1) % 256;
            end
         end
         if (do_push) begin
            e.ix  = bus_if.aw_ix;
            e.mr  = bus_if.aw_mr;
            e.len = int'(bus_if.aw_len);
            q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus_if.aw_valid = 1'b0;
      bus_if.aw_ready = 1'b0;
      bus_if.aw_ix    = '0;
      bus_if.aw_mr    = 1'b0;
      bus_if.aw_len   = '0;
      bus_if.w_valid  = 1'b0;
      bus_if.w_last   = 1'b0;
   endtask

   task automatic aw(input logic [3:0] ix, input bit mr, input int len);
      bus_if.aw_valid = 1'b1;
      bus_if.aw_ready = 1'b1;
      bus_if.aw_ix    = ix;
      bus_if.aw_mr    = mr;
      bus_if.aw_len   = 8'(len);
   endtask

   task automatic no_aw();
      bus_if.aw_valid = 1'b0;
      bus_if.aw_ready = 1'b0;
   endtask

   task automatic beat(input bit last);
      bus_if.w_valid = 1'b1;
      bus_if.w_last  = last;
   endtask

   initial begin
      n_chk = 0; n_pass = 0; mcnt = 0; err_pend = 1'b0;
      srst = 1'b1;
      idle();
      bus_if.slv_wready = '0;
      repeat (3) @(posedge clk);
      #1;
      cycle();
      srst = 1'b0;
      chk("rst_grant", 32'(bus_if.w_grant), 32'd0);
      chk("rst_ready", 32'(bus_if.w_ready), 32'd0);
      chk("rst_full", 32'(bus_if.aw_full), 32'd0);

      // Single write to slave 2, four beats.
      bus_if.slv_wready = 4'b0100;
      aw(4'b0100, 1'b0, 3); cycle();
      no_aw();
      chk("sw_grant_aw1", 32'(bus_if.w_grant), 32'h4);
      for (int i = 0; i < 4; i++) begin beat(i == 3); cycle(); end
      idle();
      chk("sw_grant_done", 32'(bus_if.w_grant), 32'd0);
      cycle();

      // W valid ahead of its AW stalls.
      bus_if.slv_wready = 4'b0001;
      beat(1'b0);
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("wb4aw_ready", 32'(bus_if.w_ready), 32'd0);
      end
      aw(4'b0001, 1'b0, 1); cycle();
      no_aw();
      beat(1'b0); cycle();
      beat(1'b1); cycle();
      idle(); cycle();

      // Back-to-back bursts to slaves 1 and 3, streamed W.
      bus_if.slv_wready = 4'b1111;
      aw(4'b0010, 1'b0, 0); cycle();
      aw(4'b1000, 1'b0, 1); beat(1'b1); cycle();
      no_aw(); beat(1'b0); cycle();
      beat(1'b1); cycle();
      idle(); cycle();

      // Fill the order FIFO, then pop and push around the full boundary.
      aw(4'b0001, 1'b0, 0); cycle();
      aw(4'b0010, 1'b0, 0); cycle();
      aw(4'b0100, 1'b0, 0); cycle();
      aw(4'b1000, 1'b0, 0); cycle();
      idle();
      chk("full_set", 32'(bus_if.aw_full), 32'd1);
      cycle();
      beat(1'b1); cycle();
      chk("full_clr", 32'(bus_if.aw_full), 32'd0);
      aw(4'b0001, 1'b0, 0); beat(1'b1); cycle();
      chk("full_pushpop", 32'(bus_if.aw_full), 32'd0);
      idle(); aw(4'b0010, 1'b0, 0); cycle();
      idle();
      chk("full_again", 32'(bus_if.aw_full), 32'd1);
      for (int i = 0; i < 4; i++) begin beat(1'b1); cycle(); end
      idle(); cycle();

      // Misrouted write is sunk without any slave ready.
      bus_if.slv_wready = 4'b0000;
      aw(4'b0000, 1'b1, 2); cycle();
      no_aw();
      chk("mr_flag", 32'(bus_if.w_mr), 32'd1);
      for (int i = 0; i < 3; i++) begin beat(i == 2); cycle(); end
      idle(); cycle();

      // Early WLAST on a two-beat burst.
      bus_if.slv_wready = 4'b0001;
      aw(4'b0001, 1'b0, 1); cycle();
      no_aw(); beat(1'b1); cycle();
      idle();
      chk("lenerr_pulse", 32'(bus_if.len_err), 32'(LEN_CHK));
      cycle();
      chk("lenerr_once", 32'(bus_if.len_err), 32'd0);

      // Reset in the middle of a burst discards everything.
      bus_if.slv_wready = 4'b0110;
      aw(4'b0010, 1'b0, 3); cycle();
      aw(4'b0100, 1'b0, 0); beat(1'b0); cycle();
      no_aw(); beat(1'b0); cycle();
      srst = 1'b1; cycle();
      srst = 1'b0;
      chk("srst_grant", 32'(bus_if.w_grant), 32'd0);
      chk("srst_ready", 32'(bus_if.w_ready), 32'd0);
      idle(); cycle();

      // Maximum burst: counter reaches 255 on the final beat.
      bus_if.slv_wready = 4'b1000;
      aw(4'b1000, 1'b0, 255); cycle();
      no_aw();
      for (int i = 0; i < 256; i++) begin beat(i == 255); cycle(); end
      idle(); cycle();
      chk("maxlen_err", 32'(bus_if.len_err), 32'd0);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         srst = ($urandom_range(0, 299) == 0);
         bus_if.aw_valid = ($urandom_range(0, 1) == 1);
         bus_if.aw_ready = (q.size() < OSTD) && ($urandom_range(0, 3) != 0);
         bus_if.aw_mr    = ($urandom_range(0, 4) == 0);
         bus_if.aw_ix    = bus_if.aw_mr ? 4'b0000 : 4'(1 << $urandom_range(0, 3));
         bus_if.aw_len   = 8'($urandom_range(0, 3));
         bus_if.w_valid  = ($urandom_range(0, 9) < 6);
         if (q.size() != 0) bus_if.w_last = (mcnt == q[0].len);
         else bus_if.w_last = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 19) == 0) bus_if.w_last = ~bus_if.w_last;
         bus_if.slv_wready = 4'($urandom_range(0, 15));
         cycle();
      end
      srst = 1'b0;
      idle();
      cycle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
